// File: rtl/tls_ped_if.sv
// Signal bundle between the vehicle controller side and the pedestrian stage.
// The master drives lamps, programmed red duration, request and Set; the
// slave (tls_ped) returns the pedestrian lamps, countdown and status.
interface tls_ped_if;
    logic       Set;
    logic       G;
    logic       Y;
    logic       R;
    logic [3:0] Rdur;
    logic       Req;
    logic       Walk;
    logic       DontWalk;
    logic       Flash;
    logic [3:0] Cnt;
    logic       ReqPend;
    logic       Fault;

    modport master (
        output Set, G, Y, R, Rdur, Req,
        input  Walk, DontWalk, Flash, Cnt, ReqPend, Fault
    );

    modport slave (
        input  Set, G, Y, R, Rdur, Req,
        output Walk, DontWalk, Flash, Cnt, ReqPend, Fault
    );
endinterface

// File: rtl/tls_ped.sv
// Pedestrian signal stage: grants WALK during vehicle red when a crossing is
// requested, follows it with a flashing DON'T-WALK clearance, drives a
// countdown and latches a sticky fault on persistent non-one-hot lamps.
module tls_ped #(
    parameter int unsigned FLASH_CYC = 3
) (
    input logic     clk,
    input logic     reset,
    tls_ped_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_CLEAR,
        S_FAULT
    } state_t;

    // Red must be long enough for at least one WALK cycle plus the clearance.
    localparam logic [4:0] WALK_MIN  = 5'(FLASH_CYC + 2);
    localparam logic [3:0] FLASH_LIM = 4'(FLASH_CYC);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] cnt_dec;
    logic       blink, blink_n;
    logic       r_prev;
    logic       req_pend, req_pend_n;
    logic       bad_prev, bad_prev_n;
    logic       bad;
    logic       rise;
    logic       grant_ok;

    // Lamp consistency, red edge detect and decrement helpers.
    always_comb begin
        bad      = (3'({2'b00, bus.G} + {2'b00, bus.Y} + {2'b00, bus.R}) != 3'd1);
        rise     = bus.R & ~r_prev;
        cnt_dec  = cnt - 4'd1;
        grant_ok = ({1'b0, bus.Rdur} >= WALK_MIN);
    end

    // Next-state logic: Set, then fault detection, then normal sequencing.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        blink_n    = blink;
        req_pend_n = req_pend;
        bad_prev_n = bad;

        if (bus.Set) begin
            state_n    = S_IDLE;
            cnt_n      = '0;
            blink_n    = 1'b0;
            bad_prev_n = 1'b0;
        end else if (bad_prev && bad) begin
            state_n = S_FAULT;
            cnt_n   = '0;
            blink_n = 1'b0;
            // A request arriving while the fault trips is still remembered,
            // except during WALK where requests are ignored.
            if (state != S_WALK) begin
                req_pend_n = req_pend | bus.Req;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    req_pend_n = req_pend | bus.Req;
                    if (rise) begin
                        cnt_n = (bus.Rdur == 4'd0) ? 4'd0 : bus.Rdur - 4'd1;
                        if ((req_pend | bus.Req) && grant_ok) begin
                            state_n    = S_WALK;
                            req_pend_n = 1'b0;
                        end
                    end
                end
                S_WALK: begin
                    if (bus.R) begin
                        cnt_n = cnt_dec;
                        if (cnt_dec <= FLASH_LIM) begin
                            state_n = S_CLEAR;
                            blink_n = 1'b1;
                        end
                    end else begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                        blink_n = 1'b0;
                    end
                end
                S_CLEAR: begin
                    req_pend_n = req_pend | bus.Req;
                    if (bus.R) begin
                        // Saturate at zero so a stalled red keeps blinking.
                        cnt_n   = (cnt == 4'd0) ? 4'd0 : cnt_dec;
                        blink_n = ~blink;
                    end else begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                        blink_n = 1'b0;
                    end
                end
                S_FAULT: begin
                    req_pend_n = req_pend | bus.Req;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            blink    <= 1'b0;
            r_prev   <= 1'b0;
            req_pend <= 1'b0;
            bad_prev <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            blink    <= blink_n;
            r_prev   <= bus.R;
            req_pend <= req_pend_n;
            bad_prev <= bad_prev_n;
        end
    end

    logic       walk_o;
    logic       dont_walk_o;
    logic       flash_o;
    logic [3:0] cnt_o;
    logic       fault_o;

    // Output decode from registers only.
    always_comb begin
        walk_o      = (state == S_WALK);
        dont_walk_o = (state == S_IDLE) || (state == S_FAULT) || ((state == S_CLEAR) && blink);
        flash_o     = (state == S_CLEAR) || (state == S_FAULT);
        cnt_o       = ((state == S_WALK) || (state == S_CLEAR)) ? cnt : 4'd0;
        fault_o     = (state == S_FAULT);
    end

    assign bus.Walk     = walk_o;
    assign bus.DontWalk = dont_walk_o;
    assign bus.Flash    = flash_o;
    assign bus.Cnt      = cnt_o;
    assign bus.ReqPend  = req_pend;
    assign bus.Fault    = fault_o;

endmodule

// File: tb/tb_tls_ped.sv
// Directed table-driven bench for tls_ped with FLASH_CYC=3.
module tb_tls_ped;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    tls_ped_if bus();

    tls_ped #(.FLASH_CYC(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       g;
        logic       y;
        logic       r;
        logic [3:0] rdur;
        logic       req;
        logic       set;
        logic       walk;
        logic       dont_walk;
        logic       flash;
        logic [3:0] cnt;
        logic       req_pend;
        logic       fault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int g, input int y, input int r, input int rdur,
                       input int req, input int set,
                       input int w, input int dw, input int fl, input int c,
                       input int rp, input int fa);
        vec_t v;
        v.g = g[0]; v.y = y[0]; v.r = r[0]; v.rdur = rdur[3:0];
        v.req = req[0]; v.set = set[0];
        v.walk = w[0]; v.dont_walk = dw[0]; v.flash = fl[0];
        v.cnt = c[3:0]; v.req_pend = rp[0]; v.fault = fa[0];
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (row %0d): got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input int w, input int dw,
                           input int fl, input int c, input int rp, input int fa);
        chk({tag, ".Walk"},     idx, {3'b0, bus.Walk},     w[3:0]);
        chk({tag, ".DontWalk"}, idx, {3'b0, bus.DontWalk}, dw[3:0]);
        chk({tag, ".Flash"},    idx, {3'b0, bus.Flash},    fl[3:0]);
        chk({tag, ".Cnt"},      idx, bus.Cnt,              c[3:0]);
        chk({tag, ".ReqPend"},  idx, {3'b0, bus.ReqPend},  rp[3:0]);
        chk({tag, ".Fault"},    idx, {3'b0, bus.Fault},    fa[3:0]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic g, input logic y, input logic r, input logic [3:0] rdur,
                         input logic req, input logic set);
        bus.G = g; bus.Y = y; bus.R = r; bus.Rdur = rdur; bus.Req = req; bus.Set = set;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;

        //   g y r rd rq st | W DW F C RP Fa
        // No request: red passes without WALK.
        add(1,0,0,8,0,0, 0,1,0,0,0,0);
        for (int i = 0; i < 8; i++) add(0,0,1,8,0,0, 0,1,0,0,0,0);
        add(1,0,0,8,0,0, 0,1,0,0,0,0);
        // Request during green, full WALK/CLEAR cycle, stalled red, request in CLEAR.
        add(1,0,0,8,1,0, 0,1,0,0,1,0);
        add(1,0,0,8,0,0, 0,1,0,0,1,0);
        add(0,0,1,8,0,0, 1,0,0,7,0,0);
        add(0,0,1,8,0,0, 1,0,0,6,0,0);
        add(0,0,1,8,0,0, 1,0,0,5,0,0);
        add(0,0,1,8,0,0, 1,0,0,4,0,0);
        add(0,0,1,8,0,0, 0,1,1,3,0,0);
        add(0,0,1,8,0,0, 0,0,1,2,0,0);
        add(0,0,1,8,1,0, 0,1,1,1,1,0);
        add(0,0,1,8,0,0, 0,0,1,0,1,0);
        add(0,0,1,8,0,0, 0,1,1,0,1,0);
        add(0,0,1,8,0,0, 0,0,1,0,1,0);
        add(1,0,0,8,0,0, 0,1,0,0,1,0);
        // Red too short (4 < 5): request stays pending, served at next long red.
        add(1,0,0,8,1,0, 0,1,0,0,1,0);
        add(0,0,1,4,0,0, 0,1,0,0,1,0);
        add(0,0,1,4,0,0, 0,1,0,0,1,0);
        add(1,0,0,4,0,0, 0,1,0,0,1,0);
        add(0,1,0,4,0,0, 0,1,0,0,1,0);
        add(0,0,1,8,0,0, 1,0,0,7,0,0);
        add(0,0,1,8,0,0, 1,0,0,6,0,0);
        add(1,0,0,8,0,0, 0,1,0,0,0,0);
        // Boundary Rdur = FLASH_CYC+2: one WALK cycle.
        add(1,0,0,8,1,0, 0,1,0,0,1,0);
        add(0,0,1,5,0,0, 1,0,0,4,0,0);
        add(0,0,1,5,0,0, 0,1,1,3,0,0);
        add(0,0,1,5,0,0, 0,0,1,2,0,0);
        add(1,0,0,5,0,0, 0,1,0,0,0,0);
        // Request during WALK is ignored; next red has no WALK.
        add(1,0,0,8,1,0, 0,1,0,0,1,0);
        add(0,0,1,8,0,0, 1,0,0,7,0,0);
        add(0,0,1,8,1,0, 1,0,0,6,0,0);
        add(0,0,1,8,1,0, 1,0,0,5,0,0);
        add(1,0,0,8,0,0, 0,1,0,0,0,0);
        add(0,0,1,8,0,0, 0,1,0,0,0,0);
        add(0,0,1,8,0,0, 0,1,0,0,0,0);
        add(1,0,0,8,0,0, 0,1,0,0,0,0);
        // Request on the same edge as the red rise is served.
        add(0,0,1,8,1,0, 1,0,0,7,0,0);
        add(1,0,0,8,0,0, 0,1,0,0,0,0);
        // Single bad edge ignored; two consecutive trip a sticky fault; Set clears it.
        add(1,0,1,8,0,0, 0,1,0,0,0,0);
        add(1,0,0,8,0,0, 0,1,0,0,0,0);
        add(1,0,1,8,0,0, 0,1,0,0,0,0);
        add(1,0,1,8,0,0, 0,1,1,0,0,1);
        add(1,0,0,8,0,0, 0,1,1,0,0,1);
        add(1,0,0,8,1,0, 0,1,1,0,1,1);
        add(0,1,0,8,0,0, 0,1,1,0,1,1);
        add(1,0,0,8,0,1, 0,1,0,0,1,0);
        add(1,0,0,8,0,0, 0,1,0,0,1,0);
        // Enter WALK for the asynchronous reset sequence below.
        add(0,0,1,8,0,0, 1,0,0,7,0,0);
        add(0,0,1,8,0,0, 1,0,0,6,0,0);
        add(0,0,1,8,0,0, 1,0,0,5,0,0);

        // Reset state.
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b0);
        step();
        step();
        chk_all("reset", -1, 0, 1, 0, 0, 0, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].g, vecs[i].y, vecs[i].r, vecs[i].rdur, vecs[i].req, vecs[i].set);
            step();
            chk_all("vec", i, int'(vecs[i].walk), int'(vecs[i].dont_walk), int'(vecs[i].flash),
                    int'(vecs[i].cnt), int'(vecs[i].req_pend), int'(vecs[i].fault));
        end

        // Asynchronous reset mid-WALK: outputs drop without waiting for an edge.
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", -1, 0, 1, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;
        // Red still high after release; no request pending so no WALK.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("post_rst", i, 0, 1, 0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
